// File: rtl/rc4_key_search_sequencer.sv
// Top-level sequencer for the RC4 key search: walks candidate keys, runs the
// per-key sub-tasks over start/finish handshakes and samples the checker verdict.
module rc4_key_search_sequencer #(
    parameter int              NUM_TASKS      = 3,
    parameter int              KEY_W          = 24,
    parameter logic [KEY_W-1:0] KEY_START     = '0,
    parameter logic [KEY_W-1:0] KEY_END       = KEY_W'('h3FFFFF),
    parameter int              TIMEOUT_CYCLES = 0,
    parameter int              SEL_W          = $clog2(NUM_TASKS + 1)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [NUM_TASKS-1:0] task_finish,
    input  logic                 key_valid,
    output logic [NUM_TASKS-1:0] task_start,
    output logic [SEL_W-1:0]     select_task,
    output logic [KEY_W-1:0]     key,
    output logic                 busy,
    output logic                 done,
    output logic                 key_found,
    output logic                 timeout_err
);

    localparam int TASK_W = (NUM_TASKS > 1) ? $clog2(NUM_TASKS) : 1;
    localparam int TMR_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TASK_W-1:0] LAST_TASK = TASK_W'(NUM_TASKS - 1);
    localparam logic [TMR_W-1:0]  TMR_LAST  =
        TMR_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START_TASK,
        S_WAIT_TASK,
        S_CHECK,
        S_NEXT_KEY,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [NUM_TASKS-1:0] task_start;
        logic [SEL_W-1:0]     select_task;
        logic                 busy;
        logic                 done;
    } outs_t;

    state_t            state;
    logic [TASK_W-1:0] task_idx;
    logic [TMR_W-1:0]  timer;
    outs_t             outs_q;

    // Output image of a state, registered alongside the transition into it.
    function automatic outs_t decode(input state_t s, input logic [TASK_W-1:0] t);
        outs_t o;
        o = '0;
        case (s)
            S_START_TASK: begin
                o.task_start  = NUM_TASKS'(1) << t;
                o.select_task = SEL_W'(t) + SEL_W'(1);
                o.busy        = 1'b1;
            end
            S_WAIT_TASK: begin
                o.select_task = SEL_W'(t) + SEL_W'(1);
                o.busy        = 1'b1;
            end
            S_CHECK: begin
                o.select_task = SEL_W'(NUM_TASKS);
                o.busy        = 1'b1;
            end
            S_NEXT_KEY: o.busy = 1'b1;
            S_DONE:     o.done = 1'b1;
            default:    o = '0;
        endcase
        return o;
    endfunction

    // NOTE: all state updates use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            key         <= KEY_START;
            task_idx    <= '0;
            timer       <= '0;
            key_found   <= 1'b0;
            timeout_err <= 1'b0;
            outs_q      <= '0;
        end else if (abort && (state inside {S_START_TASK, S_WAIT_TASK, S_CHECK, S_NEXT_KEY})) begin
            state       <= S_IDLE;
            key         <= KEY_START;
            task_idx    <= '0;
            timer       <= '0;
            key_found   <= 1'b0;
            timeout_err <= 1'b0;
            outs_q      <= decode(S_IDLE, '0);
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state       <= S_START_TASK;
                        key         <= KEY_START;
                        task_idx    <= '0;
                        key_found   <= 1'b0;
                        timeout_err <= 1'b0;
                        outs_q      <= decode(S_START_TASK, '0);
                    end
                end
                S_START_TASK: begin
                    // A finish coincident with the start pulse is deliberately not sampled.
                    timer  <= '0;
                    state  <= S_WAIT_TASK;
                    outs_q <= decode(S_WAIT_TASK, task_idx);
                end
                S_WAIT_TASK: begin
                    if (task_finish[task_idx]) begin
                        if (task_idx == LAST_TASK) begin
                            state  <= S_CHECK;
                            outs_q <= decode(S_CHECK, task_idx);
                        end else begin
                            task_idx <= task_idx + TASK_W'(1);
                            state    <= S_START_TASK;
                            outs_q   <= decode(S_START_TASK, task_idx + TASK_W'(1));
                        end
                    end else if (TIMEOUT_CYCLES != 0 && timer == TMR_LAST) begin
                        state       <= S_DONE;
                        timeout_err <= 1'b1;
                        key_found   <= 1'b0;
                        outs_q      <= decode(S_DONE, '0);
                    end else if (TIMEOUT_CYCLES != 0) begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                S_CHECK: begin
                    if (key_valid) begin
                        state     <= S_DONE;
                        key_found <= 1'b1;
                        outs_q    <= decode(S_DONE, '0);
                    end else if (key == KEY_END) begin
                        state     <= S_DONE;
                        key_found <= 1'b0;
                        outs_q    <= decode(S_DONE, '0);
                    end else begin
                        state  <= S_NEXT_KEY;
                        outs_q <= decode(S_NEXT_KEY, '0);
                    end
                end
                S_NEXT_KEY: begin
                    // The range end is caught in CHECK, so this increment never wraps.
                    key      <= key + KEY_W'(1);
                    task_idx <= '0;
                    state    <= S_START_TASK;
                    outs_q   <= decode(S_START_TASK, '0);
                end
                default: begin
                    state  <= S_IDLE;
                    outs_q <= '0;
                end
            endcase
        end
    end

    assign task_start  = outs_q.task_start;
    assign select_task = outs_q.select_task;
    assign busy        = outs_q.busy;
    assign done        = outs_q.done;

endmodule

// File: tb/tb_rc4_key_search_sequencer.sv
// Self-checking bench for rc4_key_search_sequencer: directed scenarios plus
// randomized searches, checked against an outcome model of the key walk.
module tb_rc4_key_search_sequencer;

    localparam int              NT = 3;
    localparam int              KW = 24;
    localparam int              TO = 8;
    localparam logic [KW-1:0]   KS = '0;
    localparam logic [KW-1:0]   KE = 24'd3;
    localparam int              SW = $clog2(NT + 1);

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          key_valid = 1'b0;
    logic [NT-1:0] task_finish = '0;
    logic [NT-1:0] task_start;
    logic [SW-1:0] select_task;
    logic [KW-1:0] key;
    logic          busy, done, key_found, timeout_err;

    int   n_tests = 0;
    int   n_fail = 0;
    int   pulse_cnt = 0;
    logic key_over = 1'b0;

    always #5 clk = ~clk;

    rc4_key_search_sequencer #(
        .NUM_TASKS(NT), .KEY_W(KW), .KEY_START(KS), .KEY_END(KE), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .task_finish(task_finish), .key_valid(key_valid),
        .task_start(task_start), .select_task(select_task), .key(key),
        .busy(busy), .done(done), .key_found(key_found), .timeout_err(timeout_err)
    );

    // Independent monitor: counts start pulses and flags any key beyond the range end.
    always @(negedge clk) begin
        pulse_cnt <= pulse_cnt + $countones(task_start);
        if (key > KE) key_over <= 1'b1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Status vector {busy, done, select_task, task_start} for compact state checks.
    function automatic logic [31:0] status();
        return 32'({busy, done, select_task, task_start});
    endfunction

    function automatic logic [31:0] stat(input logic b, input logic d, input int sel, input int ts);
        return 32'({b, d, SW'(sel), NT'(ts)});
    endfunction

    // Wait (bounded) for the next start pulse; it must appear one cycle later.
    task automatic wait_start(input int t, input int k);
        int lat;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            start = 1'b0;
            task_finish = '0;
        end while (task_start == '0 && lat < 12);
        check("start_latency", lat, 1);
        check("task_start", 32'(task_start), 32'(1) << t);
        check("select_start", 32'(select_task), t + 1);
        check("key_at_start", 32'(key), k);
        check("flags_at_start", {key_found, timeout_err, done}, 0);
    endtask

    // Called at the start-pulse cycle: finish task t after d wait cycles,
    // with noise on the other finish bits, on start and on key_valid.
    task automatic serve_task(input int t, input int d);
        task_finish = ($urandom_range(0, 1) == 1) ? NT'(1) << t : '0;
        key_valid = 1'($urandom);
        for (int i = 1; i <= d; i++) begin
            @(negedge clk);
            check("wait_status", status(), stat(1'b1, 1'b0, t + 1, 0));
            if (i < d) begin
                task_finish = NT'($urandom) & ~(NT'(1) << t);
                start = 1'($urandom);
            end else begin
                task_finish = NT'(1) << t;
                start = 1'b0;
            end
        end
    endtask

    // Called at the last finish of key k: walk CHECK and then DONE or NEXT_KEY.
    task automatic finish_key(input int k, input logic is_final, input logic found);
        @(negedge clk);
        task_finish = '0;
        check("check_status", status(), stat(1'b1, 1'b0, NT, 0));
        @(negedge clk);
        key_valid = 1'($urandom);
        if (is_final) begin
            check("done_status", status(), stat(1'b0, 1'b1, 0, 0));
            check("done_key", 32'(key), k);
            check("done_found", 32'(key_found), 32'(found));
            check("done_timeout", 32'(timeout_err), 0);
        end else begin
            check("next_key_status", status(), stat(1'b1, 1'b0, 0, 0));
        end
    endtask

    // Full search from IDLE or DONE; good beyond KE means no key is ever valid.
    task automatic search(input int good, input int dmin, input int dmax);
        int   exp_final;
        logic exp_found;
        int   p0;
        exp_found = (good <= int'(KE));
        exp_final = exp_found ? good : int'(KE);
        p0 = pulse_cnt;
        start = 1'b1;
        for (int k = int'(KS); k <= exp_final; k++) begin
            for (int t = 0; t < NT; t++) begin
                wait_start(t, k);
                serve_task(t, $urandom_range(dmin, dmax));
            end
            key_valid = (k == good);
            finish_key(k, k == exp_final, exp_found);
        end
        check("pulse_count", pulse_cnt - p0, (exp_final - int'(KS) + 1) * NT);
    endtask

    initial begin
        // Reset state.
        repeat (3) @(negedge clk);
        check("reset_status", status(), 0);
        check("reset_key", 32'(key), 32'(KS));
        check("reset_flags", {key_found, timeout_err}, 0);
        reset_n = 1'b1;

        // Abort in IDLE is ignored.
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);
        check("idle_abort_status", status(), 0);

        // Found on key 2 with fixed 5-cycle task latency.
        search(2, 5, 5);

        // Range exhaustion: keys 0..3 tried, never past KE.
        search(99, 1, 3);
        check("key_never_past_end", 32'(key_over), 0);

        // Watchdog: task 1 of key 0 never finishes.
        start = 1'b1;
        wait_start(0, 0);
        serve_task(0, $urandom_range(1, 4));
        wait_start(1, 0);
        for (int i = 1; i <= TO; i++) begin
            @(negedge clk);
            check("timeout_wait", status(), stat(1'b1, 1'b0, 2, 0));
            task_finish = NT'($urandom) & ~NT'(2);
        end
        @(negedge clk);
        task_finish = '0;
        check("timeout_status", status(), stat(1'b0, 1'b1, 0, 0));
        check("timeout_flags", {timeout_err, key_found}, 2'b10);
        check("timeout_key", 32'(key), 0);
        @(negedge clk);
        check("timeout_held", {done, timeout_err}, 2'b11);

        // Finish on exactly the last watchdog cycle wins; flags clear on restart.
        search(1, TO, TO);

        // Abort in WAIT of key 1, task 2, coincident with a finish.
        start = 1'b1;
        for (int t = 0; t < NT; t++) begin
            wait_start(t, 0);
            serve_task(t, $urandom_range(1, 3));
        end
        key_valid = 1'b0;
        finish_key(0, 1'b0, 1'b0);
        for (int t = 0; t < 2; t++) begin
            wait_start(t, 1);
            serve_task(t, $urandom_range(1, 3));
        end
        wait_start(2, 1);
        @(negedge clk);
        abort = 1'b1;
        task_finish = 3'b100;
        @(negedge clk);
        abort = 1'b0;
        task_finish = '0;
        check("abort_status", status(), 0);
        check("abort_key", 32'(key), 32'(KS));
        check("abort_flags", {key_found, timeout_err}, 0);
        @(negedge clk);
        check("abort_stays_idle", status(), 0);
        search(0, 1, 4);

        // Abort in DONE is ignored.
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("done_abort_ignored", {done, key_found, busy}, 3'b110);
        check("done_abort_key", 32'(key), 0);

        // Reset mid-WAIT_TASK clears everything.
        start = 1'b1;
        wait_start(0, 0);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("midreset_status", status(), 0);
        check("midreset_key", 32'(key), 32'(KS));
        check("midreset_flags", {key_found, timeout_err}, 0);
        @(negedge clk);
        check("midreset_idle", status(), 0);

        // Prior search, then restart from DONE.
        search(3, 1, 6);
        search(1, 1, 6);

        // Randomized searches.
        for (int r = 0; r < 6; r++) begin
            search($urandom_range(0, 5), 1, TO);
        end
        check("key_never_past_end_final", 32'(key_over), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rc4_key_search_sequencer.md
Name: rc4_key_search_sequencer

Overview:
Parametrised top-level sequencer for the RC4 cracking datapath. It steps a candidate key from KEY_START to KEY_END. For each key it runs NUM_TASKS sub-tasks in order (default: init, shuffle, decode) over start/finish handshakes, then samples the plaintext checker verdict. It stops on the first valid key, on exhausting the range, on a per-task timeout, or on abort. It drives the shared-memory mux select and presents the current key to the datapath.

Parameters:
NUM_TASKS, 3, number of sequential sub-tasks per key (>=1)
KEY_W, 24, candidate key width
KEY_START, 0, first key tried
KEY_END, 24'h3FFFFF, last key tried; must be >= KEY_START (other values are illegal, behaviour undefined)
TIMEOUT_CYCLES, 0, max cycles in WAIT_TASK per task; 0 disables the watchdog
SEL_W, $clog2(NUM_TASKS+1), select_task width (derived)

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
start  in  1  begin search; sampled in IDLE and DONE only
abort  in  1  cancel search; return to IDLE
task_finish  in  NUM_TASKS  per-task finish; bit t meaningful only while task t is active
key_valid  in  1  checker verdict for current key; sampled in CHECK only
task_start  out  NUM_TASKS  one-cycle start pulse, bit t for task t
select_task  out  SEL_W  0 = idle/none; t+1 while task t is active
key  out  KEY_W  current candidate key
busy  out  1  high in START_TASK, WAIT_TASK, CHECK, NEXT_KEY
done  out  1  level, high only in DONE
key_found  out  1  valid only with done: 1 = key holds a valid key
timeout_err  out  1  valid only with done: 1 = the watchdog expired

Behaviour:
- Reset (reset_n=0 at a clk edge, takes priority over everything, including mid-task):
  - state=IDLE, key=KEY_START, task index t=0, timer=0.
  - All outputs 0, except key=KEY_START.
- States: IDLE, START_TASK, WAIT_TASK, CHECK, NEXT_KEY, DONE. All outputs are registered or decoded from the state and registers; there is no combinational path from inputs to outputs.
- IDLE:
  - start=1 -> key=KEY_START, t=0 -> START_TASK.
- START_TASK:
  - task_start[t]=1 for exactly this cycle; timer cleared.
  - task_finish is not sampled; a finish coincident with the start pulse is ignored.
  - Unconditionally -> WAIT_TASK.
- WAIT_TASK:
  - task_finish[t]=1 -> if t<NUM_TASKS-1: t+1 -> START_TASK; else -> CHECK.
  - Other task_finish bits are ignored.
  - If TIMEOUT_CYCLES!=0, timer increments each cycle. When timer reaches TIMEOUT_CYCLES with no finish -> DONE, timeout_err=1, key_found=0.
  - If finish and timeout occur in the same cycle, finish wins.
- CHECK (one cycle):
  - key_valid=1 -> DONE, key_found=1, key held.
  - Else if key==KEY_END -> DONE, key_found=0, key held at KEY_END.
  - Else -> NEXT_KEY.
- NEXT_KEY (one cycle):
  - key<=key+1, t<=0 -> START_TASK.
  - Key never wraps: the range end is caught in CHECK.
- DONE:
  - done=1; key, key_found and timeout_err are held.
  - start=1 -> clear flags, key=KEY_START, t=0 -> START_TASK (restart).
- Latency:
  - IDLE start to task_start[0]: 1 cycle.
  - Last finish to the next key's task_start[0]: 3 cycles (CHECK, NEXT_KEY, START_TASK).
- Abort:
  - abort=1 in any busy state -> IDLE next cycle.
  - task_start=0, select_task=0, flags=0, key=KEY_START.
  - done is not asserted.
  - abort is ignored in IDLE and DONE.
  - If abort and a finish occur in the same cycle, abort wins.
- start while busy is ignored.
- select_task:
  - t+1 in START_TASK and WAIT_TASK.
  - Holds NUM_TASKS in CHECK.
  - 0 in NEXT_KEY, IDLE and DONE.

Test Plan:
- NUM_TASKS=3, KEY_START=0, KEY_END=3, finish 5 cycles after each start, key_valid=1 on key=2 -> pulse order task_start 001,010,100 per key; select_task 1,2,3; done=1, key_found=1, key=2, 9 task_start pulses total.
- Same setup, key_valid never asserted -> keys 0,1,2,3 tried; done=1, key_found=0, key=3, timeout_err=0; key never reaches 4.
- TIMEOUT_CYCLES=8, task 1 never finishes -> done 8 cycles after entering WAIT_TASK for t=1; timeout_err=1, key_found=0; finish on exactly the 8th cycle -> no timeout.
- Abort asserted in WAIT_TASK of key 1, task 2 -> next cycle IDLE, busy=0, done=0, select_task=0, key=0; a later start restarts from key 0 with task_start[0].
- task_finish[0] asserted in the same cycle as task_start[0]; spurious task_finish[2] during task 0 -> both ignored; sequencer still waits for the genuine task_finish[0].
- reset_n low for 1 cycle mid-WAIT_TASK, then start in DONE after a prior search -> all outputs cleared on reset; restart begins at KEY_START with flags cleared.
